// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 8N1 by default.
// The 3-sample majority vote sits at mid-bit. False starts are rejected.
// A stop bit sampled low gives a frame_err pulse, and a held-low line
// (break) cannot retrigger reception.
// Optional feature: define UART_RX_PARITY_EN for 8E1/8O1 reception. This adds
// the PARITY_ODD parameter and the parity_err port.
module uart_rx_os #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    , output logic     parity_err
`endif
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_V0   = SW'(M - 1);
    localparam logic [SW-1:0] S_V1   = SW'(M);
    localparam logic [SW-1:0] S_V2   = SW'(M + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif

    logic          sync1_q, sync1_d;
    logic          rx_s_q, rx_s_d;
    logic [2:0]    state_q, state_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    hist_q, hist_d;   // first two vote samples; the third is rx_s itself
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    logic tick, vote_tick, wrap, maj;

    // Next-state logic: synchronizer, tick/sample counters, vote and frame FSM
    always_comb begin
        sync1_d   = rx;
        rx_s_d    = sync1_q;
        state_d   = state_q;
        armed_d   = armed_q;
        bit_d     = bit_q;
        hist_d    = hist_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        tick      = (tcnt_q == T_LAST);
        vote_tick = tick && (s_q == S_V2);
        wrap      = tick && (s_q == S_LAST);
        maj       = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
        tcnt_d    = tick ? '0 : tcnt_q + TW'(1);
        s_d       = s_q;
        if (tick) s_d = wrap ? '0 : s_q + SW'(1);
        if (tick && (s_q == S_V0 || s_q == S_V1)) hist_d = {hist_q[0], rx_s_q};

        case (state_q)
            IDLE: begin
                s_d = '0;
                if (!armed_q) begin
                    // After a break, wait for the line to return high first
                    if (rx_s_q) armed_d = 1'b1;
                end else if (!rx_s_q) begin
                    // Realign the tick phase to the start edge
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (vote_tick && maj) state_d = IDLE;
                else if (wrap) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (vote_tick) shift_d = {maj, shift_q[7:1]};
                if (wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (vote_tick) par_d = maj;
                if (wrap) state_d = STOP;
            end
`endif
            STOP: begin
                // Return to IDLE at the vote so the next start edge can be caught early
                if (vote_tick) begin
                    if (maj) begin
                        data_d = shift_q;
                        done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d = par_q ^ (^shift_q) ^ PARITY_ODD;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            armed_q <= 1'b1;
            tcnt_q  <= '0;
            s_q     <= '0;
            bit_q   <= 3'd0;
            hist_q  <= 2'b00;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            state_q <= state_d;
            armed_q <= armed_d;
            tcnt_q  <= tcnt_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            hist_q  <= hist_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench for uart_rx_os at 16 clk per bit (DIV=1).
// Expected bytes are queued as frames are driven and checked on rx_done.
module tb_uart_rx_os;

`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int BT    = 16;                 // clocks per bit
    localparam int FRAME = (10 + PB) * BT;     // clocks per frame
    localparam int LAT   = 156 + PB * BT;      // nominal rx_done latency

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_os #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
`ifdef UART_RX_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int done_cnt = 0, ferr_cnt = 0;
    int last_done = 0, prev_done = 0, start_cyc = 0;
    logic [8:0] exp_q[$];   // {parity_err, byte}

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pop the scoreboard on each byte strobe
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_cnt++;
            if (rx_done) begin
                logic [8:0] e;
                done_cnt++;
                prev_done = last_done;
                last_done = cyc;
                chk("overlap", int'(frame_err), 0);
                chk("sb_nonempty", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rx_data", int'(rx_data), int'(e[7:0]));
`ifdef UART_RX_PARITY_EN
                    chk("parity_err", int'(parity_err), int'(e[8]));
`endif
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame, LSB first; par is ignored without the parity feature
    task automatic send_raw(input logic [7:0] d, input logic par, input logic stop);
        start_cyc = cyc;
        rx = 1'b0; idle(BT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; idle(BT);
        end
`ifdef UART_RX_PARITY_EN
        rx = par; idle(BT);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop; idle(BT);
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back({1'b0, d});
        send_raw(d, ^d, 1'b1);
    endtask

    int d0, f0;

    initial begin
        idle(3);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_done", int'(rx_done), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        idle(BT * 2);

        // Single frame 0xA5, latency check
        d0 = done_cnt; f0 = ferr_cnt;
        send_good(8'hA5);
        idle(BT * 3);
        chk("a5_done_cnt", done_cnt - d0, 1);
        chk("a5_latency_ok", int'((last_done - start_cyc) >= LAT - 2 && (last_done - start_cyc) <= LAT + 2), 1);
        chk("a5_ferr", ferr_cnt - f0, 0);
        chk("a5_busy", int'(busy), 0);

        // Back-to-back 0x00 then 0xFF
        d0 = done_cnt;
        send_good(8'h00);
        send_good(8'hFF);
        idle(BT * 3);
        chk("b2b_done_cnt", done_cnt - d0, 2);
        chk("b2b_spacing", last_done - prev_done, FRAME);

        // Framing error on 0x3C, then recovery with 0x81
        d0 = done_cnt; f0 = ferr_cnt;
        send_raw(8'h3C, ^8'h3C, 1'b0);
        idle(BT * 4);
        chk("fe_ferr_cnt", ferr_cnt - f0, 1);
        chk("fe_done_cnt", done_cnt - d0, 0);
        chk("fe_rx_data_held", int'(rx_data), 'hFF);
        send_good(8'h81);
        idle(BT * 3);
        chk("fe_recover_done", done_cnt - d0, 1);

        // 5-clock glitch on idle line
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0; idle(5); rx = 1'b1; idle(BT - 5);
        chk("glitch_busy", int'(busy), 0);
        idle(BT * 12);
        chk("glitch_done", done_cnt - d0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);

        // Reset mid-data of 0x5A
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0; idle(BT);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h5A >> i); idle(BT);
        end
        chk("mid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_data", int'(rx_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(rx_done), 0);
        chk("mid_rst_ferr", int'(frame_err), 0);
        rx = 1'b1;
        idle(4);
        rst_n = 1'b1;
        idle(BT * 12);
        chk("mid_no_strobe", (done_cnt - d0) + (ferr_cnt - f0), 0);

        // Break: 40 bit-times low
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0; idle(BT * 40);
        chk("brk_ferr_cnt", ferr_cnt - f0, 1);
        chk("brk_done_cnt", done_cnt - d0, 0);
        chk("brk_busy", int'(busy), 0);
        rx = 1'b1; idle(BT * 2);
        send_good(8'h5A);
        idle(BT * 3);
        chk("brk_recover_done", done_cnt - d0, 1);
        chk("brk_recover_data", int'(rx_data), 'h5A);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0xA5 has four ones, so parity bit 0 is correct
        d0 = done_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        send_raw(8'hA5, 1'b0, 1'b1);
        idle(BT * 3);
        exp_q.push_back({1'b1, 8'hA5});
        send_raw(8'hA5, 1'b1, 1'b1);
        idle(BT * 3);
        chk("par_done_cnt", done_cnt - d0, 2);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
